// File: rtl/encoder_move_controller.sv
// Closed-loop move sequencer: drives H-bridge dir/PWM enable toward a commanded encoder position.
// Latency: command accepted -> MOVE next cycle; motor_en/motor_dir/done/fault registered (one clk after decision).
// Backpressure: cmd_ready_o high only in IDLE/FAULT and never while abort_i; no command queueing.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   position_i       signed decoder count (already synchronous to clk)
//   cmd_valid_i/cmd_ready_o/cmd_target_i   target handshake
//   abort_i          level abort, forces IDLE with motor off
//   motor_en_o       PWM enable to H-bridge
//   motor_dir_o      1 = drive toward increasing position
//   busy_o           high in MOVE/SETTLE
//   done_o           one-cycle pulse on successful completion
//   fault_o          high in FAULT (stall or retries exhausted)
module encoder_move_controller #(
    parameter int PWM_BITS      = 8,
    parameter int FAST_DUTY     = 200,
    parameter int SLOW_DUTY     = 60,
    parameter int SLOW_ZONE     = 64,
    parameter int TOL           = 2,
    parameter int SETTLE_CYCLES = 50000,
    parameter int STALL_CYCLES  = 2000000,
    parameter int MAX_RETRY     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] position_i,
    input  logic               cmd_valid_i,
    input  logic signed [15:0] cmd_target_i,
    output logic               cmd_ready_o,
    input  logic               abort_i,
    output logic               motor_en_o,
    output logic               motor_dir_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               fault_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 2);
    localparam int STL_W = $clog2(STALL_CYCLES + 2);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [16:0]      TOL_L       = 17'(TOL);
    localparam logic [16:0]      ZONE_L      = 17'(SLOW_ZONE);
    localparam logic [31:0]      FAST_L      = 32'(FAST_DUTY);
    localparam logic [31:0]      SLOW_L      = 32'(SLOW_DUTY);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [STL_W-1:0] STALL_LAST  = STL_W'(STALL_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX   = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SETTLE,
        ST_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic signed [15:0]   target_q, target_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic [STL_W-1:0]     stall_q, stall_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic signed [15:0]   pos_prev_q, pos_prev_d;
    logic                 motor_en_q, motor_en_d;
    logic                 motor_dir_q, motor_dir_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;

    // Error is formed one bit wider than the operands so a full-range
    // target/position difference never wraps.
    logic signed [16:0]   err_s;
    logic [16:0]          aerr;
    logic                 on_target;
    logic                 pwm_on;
    logic                 pos_moved;
    logic [STL_W-1:0]     stall_inc;
    logic [31:0]          duty;

    assign err_s     = {target_q[15], target_q} - {position_i[15], position_i};
    assign aerr      = err_s[16] ? $unsigned(-err_s) : $unsigned(err_s);
    assign on_target = (aerr <= TOL_L);
    assign duty      = (aerr > ZONE_L) ? FAST_L : SLOW_L;
    // Compared at 32 bits so a duty of 2**PWM_BITS or more means always on.
    assign pwm_on    = (32'(pwm_cnt_q) < duty);
    assign pos_moved = (position_i != pos_prev_q);
    assign stall_inc = stall_q + STL_W'(1);

    assign cmd_ready_o = ((state_q == ST_IDLE) || (state_q == ST_FAULT)) && !abort_i;
    assign busy_o      = (state_q == ST_MOVE) || (state_q == ST_SETTLE);
    assign motor_en_o  = motor_en_q;
    assign motor_dir_o = motor_dir_q;
    assign done_o      = done_q;
    assign fault_o     = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            retry_q     <= '0;
            stall_q     <= '0;
            settle_q    <= '0;
            pwm_cnt_q   <= '0;
            pos_prev_q  <= '0;
            motor_en_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            retry_q     <= retry_d;
            stall_q     <= stall_d;
            settle_q    <= settle_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pos_prev_q  <= pos_prev_d;
            motor_en_q  <= motor_en_d;
            motor_dir_q <= motor_dir_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        retry_d     = retry_q;
        stall_d     = stall_q;
        settle_d    = settle_q;
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        pos_prev_d  = position_i;
        motor_en_d  = 1'b0;
        motor_dir_d = motor_dir_q;
        done_d      = 1'b0;
        fault_d     = fault_q;

        if (abort_i) begin
            state_d  = ST_IDLE;
            fault_d  = 1'b0;
            stall_d  = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAULT: begin
                    if (cmd_valid_i) begin
                        target_d = cmd_target_i;
                        retry_d  = '0;
                        stall_d  = '0;
                        settle_d = '0;
                        fault_d  = 1'b0;
                        state_d  = ST_MOVE;
                    end
                end

                ST_MOVE: begin
                    motor_dir_d = !err_s[16] && (err_s != '0);
                    if (on_target) begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end else if (!pos_moved && (stall_inc == STALL_LAST)) begin
                        // Counter reaches its last value on the STALL_CYCLES-th
                        // cycle since the position last changed.
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        motor_en_d = pwm_on;
                        stall_d    = pos_moved ? '0 : stall_inc;
                    end
                end

                ST_SETTLE: begin
                    settle_d = settle_q + SET_W'(1);
                    if (settle_q == SETTLE_LAST) begin
                        if (on_target) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else if (retry_q == RETRY_MAX) begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                        end else begin
                            retry_d  = retry_q + RTY_W'(1);
                            stall_d  = '0;
                            settle_d = '0;
                            state_d  = ST_MOVE;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_move_controller.sv
module tb_encoder_move_controller;

    localparam int EV_DONE  = 1;
    localparam int EV_FAULT = 2;

    typedef struct {
        int kind;
        int lo;
        int hi;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] position_i;
    logic               cmd_valid_i;
    logic signed [15:0] cmd_target_i;
    logic               cmd_ready_o;
    logic               abort_i;
    logic               motor_en_o;
    logic               motor_dir_o;
    logic               busy_o;
    logic               done_o;
    logic               fault_o;

    encoder_move_controller #(
        .PWM_BITS(4), .FAST_DUTY(12), .SLOW_DUTY(4), .SLOW_ZONE(8), .TOL(1),
        .SETTLE_CYCLES(4), .STALL_CYCLES(16), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .position_i(position_i), .cmd_valid_i(cmd_valid_i),
        .cmd_target_i(cmd_target_i), .cmd_ready_o(cmd_ready_o), .abort_i(abort_i),
        .motor_en_o(motor_en_o), .motor_dir_o(motor_dir_o), .busy_o(busy_o),
        .done_o(done_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Motor model state
    int pos = 0;
    int half = 0;
    bit frozen = 0;
    bit os_armed = 0;
    int os_target = 0;
    int os_cnt = 0;
    int since_chg = 0;
    int n_done = 0;
    bit fault_prev = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic sb_event(input int kind);
        exp_t e;
        int   clamp;
        check("sb_pending", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_kind", kind, e.kind);
            if (kind == EV_DONE) begin
                clamp = (pos < e.lo) ? e.lo : ((pos > e.hi) ? e.hi : pos);
                check("sb_pos", pos, clamp);
            end
        end
    endtask

    task automatic model_update();
        bit changed = 0;
        if (!frozen && motor_en_o) begin
            half++;
            if (half == 2) begin
                half = 0;
                pos += motor_dir_o ? 1 : -1;
                changed = 1;
            end
        end
        // Coast past the target shortly after the controller has stopped driving.
        if (os_armed && pos == os_target + 1) begin
            os_cnt++;
            if (os_cnt == 3) begin
                pos = os_target - 3;
                os_armed = 0;
                changed = 1;
            end
        end
        if (changed) since_chg = 0;
        position_i = 16'(pos);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        since_chg++;
        if (done_o) begin
            n_done++;
            sb_event(EV_DONE);
        end
        if (fault_o && !fault_prev) sb_event(EV_FAULT);
        fault_prev = fault_o;
        model_update();
    endtask

    task automatic send_cmd(input int tgt);
        cmd_valid_i  = 1'b1;
        cmd_target_i = 16'(tgt);
        #1;
        check("cmd_ready", int'(cmd_ready_o), 1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy_o) break;
        end
        check(tag, int'(busy_o), 0);
    endtask

    initial begin
        int cnt;
        int base;
        int n_flt;
        bit saw_up;

        rst = 1'b1; cmd_valid_i = 1'b0; cmd_target_i = '0; abort_i = 1'b0;
        position_i = '0;
        repeat (3) tick();
        check("rst_en", int'(motor_en_o), 0);
        check("rst_dir", int'(motor_dir_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_fault", int'(fault_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_ready", int'(cmd_ready_o), 1);
        rst = 1'b0;
        tick();

        // 1: 0 -> +40, fast then slow duty, single done
        base = n_done;
        sb_q.push_back('{EV_DONE, 39, 41});
        send_cmd(40);
        check("t1_busy", int'(busy_o), 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (motor_en_o) cnt++;
        end
        check("t1_fast_duty", cnt, 12);
        check("t1_dir", int'(motor_dir_o), 1);
        for (int i = 0; i < 500; i++) begin
            tick();
            if (pos >= 33) break;
        end
        check("t1_reach33", pos, 33);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (motor_en_o) cnt++;
        end
        check("t1_slow_duty", cnt, 4);
        run_until_idle("t1_timeout", 500);
        repeat (5) tick();
        check("t1_done_cnt", n_done - base, 1);
        check("t1_en_off", int'(motor_en_o), 0);

        // 2: 0 -> -20 with one overshoot, retry, then done
        pos = 0; position_i = '0;
        os_armed = 1; os_target = -20; os_cnt = 0;
        saw_up = 0; n_flt = 0; base = n_done;
        repeat (2) tick();
        sb_q.push_back('{EV_DONE, -21, -19});
        send_cmd(-20);
        repeat (3) tick();
        check("t2_dir_down", int'(motor_dir_o), 0);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (fault_o) n_flt++;
            if (busy_o && motor_dir_o && !os_armed) saw_up = 1;
            if (!busy_o) break;
        end
        check("t2_timeout", int'(busy_o), 0);
        check("t2_overshoot", int'(os_armed), 0);
        check("t2_retry_up", int'(saw_up), 1);
        check("t2_no_fault", n_flt, 0);
        check("t2_done_cnt", n_done - base, 1);

        // 3: stall -> fault 16 clk after last position change
        sb_q.push_back('{EV_FAULT, 0, 0});
        send_cmd(100);
        repeat (30) tick();
        frozen = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fault_o) break;
        end
        check("t3_fault", int'(fault_o), 1);
        check("t3_stall_lat", since_chg, 16);
        check("t3_en", int'(motor_en_o), 0);
        check("t3_ready", int'(cmd_ready_o), 1);

        // 4: new command from FAULT clears it and completes
        frozen = 0;
        sb_q.push_back('{EV_DONE, -1, 1});
        send_cmd(0);
        check("t4_fault_clr", int'(fault_o), 0);
        check("t4_busy", int'(busy_o), 1);
        run_until_idle("t4_timeout", 1500);

        // 5: abort with cmd_valid mid-move, then held in IDLE
        base = n_done;
        send_cmd(50);
        repeat (20) tick();
        abort_i = 1'b1; cmd_valid_i = 1'b1; cmd_target_i = 16'(7);
        #1;
        check("t5_ready_move", int'(cmd_ready_o), 0);
        tick();
        check("t5_idle", int'(busy_o), 0);
        check("t5_en", int'(motor_en_o), 0);
        #1;
        check("t5_ready_abort", int'(cmd_ready_o), 0);
        tick();
        check("t5_not_acc", int'(busy_o), 0);
        abort_i = 1'b0; cmd_valid_i = 1'b0;
        repeat (10) tick();
        check("t5_stay_idle", int'(busy_o), 0);
        check("t5_no_done", n_done - base, 0);

        // 6: cmd ignored while busy, then reset mid-move
        send_cmd(80);
        repeat (10) tick();
        cmd_valid_i = 1'b1; cmd_target_i = -16'sd50;
        #1;
        check("t6_ready_busy", int'(cmd_ready_o), 0);
        tick();
        cmd_valid_i = 1'b0;
        repeat (20) tick();
        check("t6_target_kept", int'(motor_dir_o), 1);
        check("t6_busy", int'(busy_o), 1);
        rst = 1'b1;
        tick();
        check("t6_rst_en", int'(motor_en_o), 0);
        check("t6_rst_dir", int'(motor_dir_o), 0);
        check("t6_rst_done", int'(done_o), 0);
        check("t6_rst_fault", int'(fault_o), 0);
        check("t6_rst_busy", int'(busy_o), 0);
        check("t6_rst_ready", int'(cmd_ready_o), 1);
        rst = 1'b0;
        repeat (5) tick();

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
